bcd_seq_conv: RTL and testbench

Sequential double-dabble converter that turns the CPU's binary output value into packed BCD digits for the seven-segment decoders and cathode scanner. It sits directly between the CPU `out` bus and the per-digit `seven_seg` decoders, and replaces the combinational binary-to-BCD path. It converts one value per request using a valid/ready handshake, taking one iteration per clock. Results are held stable between conversions so the display scanner never sees intermediate values.

---
 rtl/bcd_seq_conv.sv | 125 ++++++++++++
 tb/tb_bcd_seq_conv.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_conv.sv
// Sequential double-dabble binary-to-BCD converter, one iteration per clock.
// Define BCD_SEQ_CONV_BLANK_EN for leading-zero blanking (4'hF) at write-back.
module bcd_seq_conv #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid,
  output logic                  busy
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_q, state_nxt;
  logic [WIDTH-1:0] bin_q, bin_nxt;
  logic [BW-1:0]   scr_q, scr_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic [BW-1:0]   bcd_q, bcd_nxt;
  logic            vld_q, vld_nxt;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    scr_sh;
  logic [WIDTH-1:0] bin_sh;
  logic [BW-1:0]    wb;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign bcd_out   = bcd_q;
  assign out_valid = vld_q;

  // Per-digit add-3 correction; digits never carry into each other.
  always_comb begin
    adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (scr_q[4*k +: 4] >= 4'd5)
        adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
      else
        adj[4*k +: 4] = scr_q[4*k +: 4];
    end
  end

  assign {scr_sh, bin_sh} = {adj, bin_q} << 1;

`ifdef BCD_SEQ_CONV_BLANK_EN
  // Blank zero digits from the top down; the ones digit always shows.
  function automatic logic [BW-1:0] blank(input logic [BW-1:0] v);
    logic lead;
    blank = v;
    lead  = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lead && (v[4*k +: 4] == 4'd0))
        blank[4*k +: 4] = 4'hF;
      else
        lead = 1'b0;
    end
  endfunction

  assign wb = blank(scr_sh);
`else
  assign wb = scr_sh;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    bin_nxt   = bin_q;
    scr_nxt   = scr_q;
    cnt_nxt   = cnt_q;
    bcd_nxt   = bcd_q;
    vld_nxt   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_nxt   = bin_in;
          scr_nxt   = '0;
          cnt_nxt   = CW'(WIDTH);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        bin_nxt = bin_sh;
        scr_nxt = scr_sh;
        cnt_nxt = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_nxt   = wb;
          vld_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      bcd_q <= '0;
      vld_q <= 1'b0;
    end else begin
      bin_q <= bin_nxt;
      scr_q <= scr_nxt;
      cnt_q <= cnt_nxt;
      bcd_q <= bcd_nxt;
      vld_q <= vld_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Bench for bcd_seq_conv: directed handshake scenarios, random and exhaustive
// conversions checked against a decimal-arithmetic reference.
module tb_bcd_seq_conv;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int BW     = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] bin_in = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [BW-1:0]    bcd_out;
  logic             out_valid;
  logic             busy;

  int checks = 0;
  int failures = 0;

  bcd_seq_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bin_in    (bin_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_out   (bcd_out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal digits by division; leading digits beyond the value's length
  // become 4'hF when blanking is enabled.
  function automatic logic [BW-1:0] ref_bcd(input int v);
    logic [BW-1:0] r;
    int rem, ndig, t;
    r = '0;
    rem = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(rem % 10);
      rem = rem / 10;
    end
    ndig = 1;
    t = v / 10;
    while (t > 0) begin
      ndig++;
      t = t / 10;
    end
`ifdef BCD_SEQ_CONV_BLANK_EN
    for (int k = 1; k < DIGITS; k++)
      if (k >= ndig) r[4*k +: 4] = 4'hF;
`endif
    return r;
  endfunction

  task automatic convert(input string tag, input int v, input bit scramble);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 30) begin
      step();
      n++;
    end
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    bin_in = WIDTH'(v);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    if (scramble) bin_in = WIDTH'($urandom);
    lat = 0;
    while (!out_valid && lat < 30) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(WIDTH));
    check({tag, "_bcd"}, 32'(bcd_out), 32'(ref_bcd(v)));
  endtask

  initial begin
    int n, pulses, lat, low;
    logic [BW-1:0] held;

    // Reset state
    #12;
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_ov", 32'(out_valid), 32'd0);
    reset = 1'b0;
    step();

    // Basic conversion of 255
    bin_in = 8'd255;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("basic_busy", 32'(busy), 32'd1);
    low = 1;
    lat = 0;
    while (!out_valid && lat < 30) begin
      step();
      lat++;
      if (!in_ready) low++;
    end
    check("basic_lat", 32'(lat), 32'd8);
    check("basic_ready_low", 32'(low), 32'd8);
    check("basic_bcd", 32'(bcd_out), 32'(ref_bcd(255)));
    check("basic_bcd_abs", 32'(bcd_out), 32'h255);
    step();
    check("basic_ov_clear", 32'(out_valid), 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) pulses++;
    end
    check("basic_hold", 32'(bcd_out), 32'h255);
    check("basic_no_pulse", 32'(pulses), 32'd0);

    // Blanking vs plain
    convert("val0", 0, 1'b0);
`ifdef BCD_SEQ_CONV_BLANK_EN
    check("val0_abs", 32'(bcd_out), 32'hFF0);
`else
    check("val0_abs", 32'(bcd_out), 32'h000);
`endif
    convert("val7", 7, 1'b0);
    convert("val42", 42, 1'b0);
    convert("val100", 100, 1'b0);
    check("val100_abs", 32'(bcd_out), 32'h100);

    // Request during conversion is ignored
    bin_in = 8'd200;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    bin_in = 8'd13;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    pulses = 0;
    held = '0;
    for (int i = 0; i < 25; i++) begin
      if (out_valid) begin
        pulses++;
        held = bcd_out;
      end
      step();
    end
    check("mid_req_pulses", 32'(pulses), 32'd1);
    check("mid_req_bcd", 32'(held), 32'(ref_bcd(200)));
    check("mid_req_not_taken", 32'(bcd_out), 32'(ref_bcd(200)));
    check("mid_req_idle", 32'(busy), 32'd0);

    // Back-to-back with held in_valid
    bin_in = 8'd99;
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    check("b2b_first", 32'(bcd_out), 32'(ref_bcd(99)));
    bin_in = 8'd128;
    n = 0;
    do begin
      step();
      n++;
    end while (!out_valid && n < 30);
    in_valid = 1'b0;
    check("b2b_gap", 32'(n), 32'd9);
    check("b2b_second", 32'(bcd_out), 32'h128);

    // Asynchronous reset mid-conversion
    step();
    bin_in = 8'd255;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    #2 reset = 1'b1;
    #1;
    check("arst_bcd", 32'(bcd_out), 32'd0);
    check("arst_ov", 32'(out_valid), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    #1 reset = 1'b0;
    step();
    convert("after_rst", 1, 1'b0);

    // Random values, gaps and scrambled bin_in during SHIFT
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(0, 3);
      for (int j = 0; j < n; j++) step();
      convert("rand", int'($urandom_range(0, 255)), 1'b1);
    end

    // Exhaustive sweep
    for (int v = 0; v < 256; v++)
      convert("sweep", v, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
